// File: rtl/s3ga_wb_master.sv
// Command/response to Wishbone classic single-transfer initiator.
// Optional bus timeout enabled by defining S3GA_WBM_TIMEOUT_EN.
module s3ga_wb_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

`ifdef S3GA_WBM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign rsp_err        = 1'b0;
`endif

    // cmd_ready is its own flop so it stays low in reset and rises one edge later.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            wbm_sel_o <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
`ifdef S3GA_WBM_TIMEOUT_EN
            rsp_err   <= 1'b0;
            to_cnt    <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= BUS;
`ifdef S3GA_WBM_TIMEOUT_EN
                        to_cnt    <= 16'd0;
`endif
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                BUS: begin
                    // An ack on the expiry edge takes priority over the timeout.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef S3GA_WBM_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                    end
`ifdef S3GA_WBM_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s3ga_wb_master.sv
// Scoreboard bench for s3ga_wb_master with a programmable Wishbone responder.
// Timeout scenarios are exercised when S3GA_WBM_TIMEOUT_EN is defined.
module tb_s3ga_wb_master;

    localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'd0;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t exp_q[$];

    int          ack_at = 0;
    bit          force_ack = 1'b0;
    bit          spurious_ack = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] rd_word = 32'd0;
    int          bus_cnt = 0;
    int          idle_cnt = 0;
    int          last_cyc_len = 0;
    int          min_gap = 1000;
    bit          seen_end = 1'b0;
    int          stb_bad = 0;

    s3ga_wb_master #(.TIMEOUT(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Responder and bus monitor: counts BUS cycles, idle gaps and stb/cyc disagreement.
    always @(posedge clk) begin
        #1;
        if (wbm_stb_o !== wbm_cyc_o) stb_bad++;
        if (wbm_cyc_o === 1'b1) begin
            if (bus_cnt == 0 && seen_end && idle_cnt < min_gap) min_gap = idle_cnt;
            bus_cnt++;
            idle_cnt = 0;
        end else begin
            if (bus_cnt != 0) begin
                last_cyc_len = bus_cnt;
                seen_end = 1'b1;
            end
            bus_cnt = 0;
            idle_cnt++;
        end
        wbm_ack_i = spurious_ack ||
                    (wbm_cyc_o === 1'b1 && (force_ack || (ack_at != 0 && bus_cnt == ack_at)));
        wbm_dat_i = use_fixed ? rd_word : (wbm_adr_o ^ RD_KEY);
    end

    task automatic send_cmd(input string name, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel,
                            input logic [31:0] exp_dat, input logic exp_err);
        exp_t e;
        bit   rdy;
        bit   ok;
        e.dat = exp_dat;
        e.err = exp_err;
        exp_q.push_back(e);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        cmd_valid = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL %s accept: command not accepted in 100 cycles, expected accept", name);
            exp_q.delete();
        end
    endtask

    task automatic get_rsp(input string name, input int hold);
        int          waited;
        int          held;
        logic [31:0] d0;
        logic        e0;
        exp_t        ex;
        waited = 0;
        rsp_ready = 1'b0;
        while (rsp_valid !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s rsp_valid: got %b after %0d cycles, expected 1", name, rsp_valid, waited);
            exp_q.delete();
            return;
        end
        d0 = rsp_dat;
        e0 = rsp_err;
        held = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1 && rsp_dat === d0 && rsp_err === e0 && cmd_ready === 1'b0) held++;
        end
        if (hold > 0) begin
            tests_run++;
            if (held != hold) begin
                tests_failed++;
                $display("[TB] FAIL %s hold: stable for %0d cycles, expected %0d", name, held, hold);
            end
        end
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s scoreboard: response dat=%h with empty queue, expected none", name, rsp_dat);
        end else begin
            ex = exp_q.pop_front();
            tests_run++;
            if (rsp_dat !== ex.dat) begin
                tests_failed++;
                $display("[TB] FAIL %s rsp_dat: got %h, expected %h", name, rsp_dat, ex.dat);
            end
            tests_run++;
            if (rsp_err !== ex.err) begin
                tests_failed++;
                $display("[TB] FAIL %s rsp_err: got %b, expected %b", name, rsp_err, ex.err);
            end
        end
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s cmd_ready_in_resp: got %b, expected 0", name, cmd_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s rsp_valid_clear: got %b, expected 0", name, rsp_valid);
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s cmd_ready_after: got %b, expected 1", name, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 71'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset wbm: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h, expected all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        tests_run++;
        if ({rsp_valid, rsp_dat, rsp_err, cmd_ready} !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset rsp: got valid=%b dat=%h err=%b cmd_ready=%b, expected all 0",
                     rsp_valid, rsp_dat, rsp_err, cmd_ready);
        end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_write();
        ack_at = 3;
        use_fixed = 1'b1;
        rd_word = 32'hFFFF_0000;
        last_cyc_len = 0;
        send_cmd("write", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tests_run++;
            if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !==
                {1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF}) begin
                tests_failed++;
                $display("[TB] FAIL write wbm_bus%0d: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h, expected 1 1 1 30000004 deadbeef f",
                         c + 1, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
            end
            @(posedge clk); #1;
        end
        get_rsp("write", 0);
        tests_run++;
        if (last_cyc_len != 3) begin
            tests_failed++;
            $display("[TB] FAIL write cyc_len: got %0d, expected 3", last_cyc_len);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        ack_at = 1;
        use_fixed = 1'b1;
        rd_word = 32'h1234_5678;
        send_cmd("read0", 1'b0, 32'h3000_0010, 32'd0, 4'hF, 32'h1234_5678, 1'b0);
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read0 early_valid: got %b at accept, expected 0", rsp_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL read0 latency: rsp_valid=%b one edge after accept, expected 1", rsp_valid);
        end
        get_rsp("read0", 0);
        use_fixed = 1'b0;
    endtask

    task automatic test_backpressure();
        ack_at = 2;
        send_cmd("bp", 1'b0, 32'h3000_0020, 32'd0, 4'h5, 32'h3000_0020 ^ RD_KEY, 1'b0);
        get_rsp("bp", 10);
    endtask

    task automatic test_ack_ignored_idle();
        spurious_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_ack: got cyc=%b rsp_valid=%b, expected 0 0", wbm_cyc_o, rsp_valid);
        end
        spurious_ack = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef S3GA_WBM_TIMEOUT_EN
    task automatic test_timeout();
        ack_at = 0;
        last_cyc_len = 0;
        send_cmd("timeout", 1'b0, 32'h3000_0040, 32'd0, 4'hF, 32'd0, 1'b1);
        get_rsp("timeout", 0);
        tests_run++;
        if (last_cyc_len != 4) begin
            tests_failed++;
            $display("[TB] FAIL timeout cyc_len: got %0d, expected 4", last_cyc_len);
        end
        ack_at = 4;
        last_cyc_len = 0;
        send_cmd("ack_at_expiry", 1'b0, 32'h3000_0044, 32'd0, 4'hF, 32'h3000_0044 ^ RD_KEY, 1'b0);
        get_rsp("ack_at_expiry", 0);
        tests_run++;
        if (last_cyc_len != 4) begin
            tests_failed++;
            $display("[TB] FAIL ack_at_expiry cyc_len: got %0d, expected 4", last_cyc_len);
        end
    endtask
`else
    task automatic test_no_timeout();
        ack_at = 0;
        send_cmd("no_timeout", 1'b0, 32'h3000_0200, 32'd0, 4'hF, 32'h3000_0200 ^ RD_KEY, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        tests_run++;
        if (wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_timeout wait: got cyc=%b rsp_valid=%b after 40 cycles, expected 1 0",
                     wbm_cyc_o, rsp_valid);
        end
        force_ack = 1'b1;
        get_rsp("no_timeout", 0);
        force_ack = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_bus();
        int vcount;
        ack_at = 0;
        send_cmd("rst_mid", 1'b1, 32'h3000_0100, 32'h1111_2222, 4'h3, 32'd0, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready} !== 72'd0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid async: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h ready=%b, expected all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) vcount++;
        end
        tests_run++;
        if (vcount != 0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid no_rsp: rsp_valid high %0d cycles, expected 0", vcount);
        end
        ack_at = 2;
        send_cmd("after_rst", 1'b0, 32'h3000_0300, 32'd0, 4'hF, 32'h3000_0300 ^ RD_KEY, 1'b0);
        get_rsp("after_rst", 0);
    endtask

    task automatic load_b2b(input int k);
        exp_t e;
        cmd_we  = k[0];
        cmd_adr = 32'h3000_0100 + 32'(k * 4);
        cmd_dat = 32'hA000_0000 | 32'(k);
        cmd_sel = 4'hF;
        e.dat = k[0] ? 32'd0 : (cmd_adr ^ RD_KEY);
        e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic test_back_to_back();
        int got;
        ack_at = 2;
        seen_end = 1'b0;
        min_gap = 1000;
        got = 0;
        rsp_ready = 1'b1;
        fork
            begin
                int  k;
                int  guard;
                bit  rdy;
                k = 0;
                guard = 0;
                load_b2b(0);
                cmd_valid = 1'b1;
                while (k < 4 && guard < 200) begin
                    rdy = cmd_ready;
                    @(posedge clk); #1;
                    guard++;
                    if (rdy) begin
                        k++;
                        if (k < 4) load_b2b(k);
                    end
                end
                cmd_valid = 1'b0;
            end
            begin
                int   guard;
                exp_t ex;
                guard = 0;
                while (got < 4 && guard < 300) begin
                    @(posedge clk); #1;
                    guard++;
                    if (rsp_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("[TB] FAIL b2b scoreboard: response %0d dat=%h with empty queue", got, rsp_dat);
                        end else begin
                            ex = exp_q.pop_front();
                            tests_run++;
                            if (rsp_dat !== ex.dat || rsp_err !== ex.err) begin
                                tests_failed++;
                                $display("[TB] FAIL b2b rsp%0d: got dat=%h err=%b, expected dat=%h err=%b",
                                         got, rsp_dat, rsp_err, ex.dat, ex.err);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        rsp_ready = 1'b0;
        tests_run++;
        if (got != 4 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b count: got %0d responses with %0d pending, expected 4 and 0", got, exp_q.size());
        end
        tests_run++;
        if (min_gap < 1 || min_gap == 1000) begin
            tests_failed++;
            $display("[TB] FAIL b2b gap: minimum cyc-low gap %0d, expected between 1 and 999", min_gap);
        end
    endtask

    task automatic test_stb_follows_cyc();
        tests_run++;
        if (stb_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL stb_eq_cyc: %0d sampled cycles differ, expected 0", stb_bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_zero_wait();
        test_backpressure();
        test_ack_ignored_idle();
`ifdef S3GA_WBM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_bus();
        test_back_to_back();
        test_stb_follows_cyc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/s3ga_wb_master.md
S3GA_WB_MASTER -- requirements
Module: s3ga_wb_master

Interface
Parameters:
REQ-001 The block SHALL have parameter TIMEOUT, default 255: bus cycles allowed per Wishbone transaction before abort; legal range 1..65535.
Ports:
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port wb_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the command ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_adr in 32, cmd_dat in 32 and cmd_sel in 4: the command request channel.
REQ-005 The block SHALL have the response ports rsp_valid out 1, rsp_ready in 1, rsp_dat out 32 and rsp_err out 1: the response channel.
REQ-006 The block SHALL have the Wishbone classic initiator outputs wbm_cyc_o 1, wbm_stb_o 1, wbm_we_o 1, wbm_adr_o 32, wbm_dat_o 32 and wbm_sel_o 4; these drive the s3ga_proj wbs_* inputs.
REQ-007 The block SHALL have the Wishbone inputs wbm_ack_i 1 and wbm_dat_i 32, driven by the responder's wbs_ack_o and wbs_dat_o.

Function
REQ-008 The block SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-009 The block SHALL drive cmd_ready high exactly when state is IDLE.
REQ-010 When cmd_valid and cmd_ready are both high at a rising edge, the block SHALL register we/adr/dat/sel into wbm_*_o, set wbm_cyc_o and wbm_stb_o high, and enter BUS.
REQ-011 The block SHALL hold all wbm_*_o outputs stable throughout BUS; all outputs are registered with no combinational path from any input to any output.
REQ-012 In BUS, wbm_ack_i high at a rising edge SHALL cause, at that edge: cyc/stb low; rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_err=0; rsp_valid=1; state RESP.
REQ-013 The block SHALL accept ack in the first BUS cycle, giving a minimum of 2 clock edges from command accept to rsp_valid.
REQ-014 The block SHALL ignore wbm_ack_i in IDLE and RESP.
REQ-015 In RESP, the block SHALL hold rsp_valid, rsp_dat and rsp_err stable until rsp_ready is sampled high; at that edge it SHALL clear rsp_valid and enter IDLE.
REQ-016 The block SHALL accept no new command in the same cycle as the response handshake; cmd_ready first rises in the cycle after.
REQ-017 Back-to-back transactions SHALL always deassert wbm_cyc_o for at least one cycle between them.
REQ-018 The block SHALL keep wbm_stb_o equal to wbm_cyc_o at all times, with no bursts or pipelined mode.

Reset
REQ-019 On wb_rst_n low, the block SHALL immediately and asynchronously set state=IDLE and drive wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0, wbm_sel_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0 and timeout counter=0.
REQ-020 The block SHALL drive cmd_ready low while reset is asserted.
REQ-021 A reset during BUS or RESP SHALL abort the transaction silently, producing no response.
REQ-022 The first command SHALL be accepted no earlier than the first rising edge after wb_rst_n deasserts.

Configuration
REQ-023 With macro S3GA_WBM_TIMEOUT_EN defined, the block SHALL include a 16-bit counter that clears on entry to BUS and increments each BUS cycle without ack.
REQ-024 With S3GA_WBM_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 without ack, the block SHALL set cyc/stb low, rsp_err=1, rsp_dat=0, rsp_valid=1 and state RESP at the next edge, so that BUS lasts exactly TIMEOUT cycles.
REQ-025 With S3GA_WBM_TIMEOUT_EN defined, ack arriving on the same edge as expiry SHALL win: normal response with rsp_err=0.
REQ-026 Without S3GA_WBM_TIMEOUT_EN, the block SHALL omit the counter, wait indefinitely in BUS, tie rsp_err to 0, and ignore TIMEOUT.

Verification
REQ-027 The bench SHALL cover a write: cmd adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, we=1; responder acks in 3rd BUS cycle -> wbm_* match; cyc high exactly 3 cycles; rsp_valid with rsp_dat=0, rsp_err=0.
REQ-028 The bench SHALL cover a read with zero-wait ack: ack in first BUS cycle, wbm_dat_i=0x1234_5678 -> rsp_valid 2 edges after accept; rsp_dat=0x1234_5678.
REQ-029 The bench SHALL cover response back-pressure: rsp_ready held low 10 cycles -> rsp_* stable; cmd_ready low throughout; cmd_ready high the cycle after handshake.
REQ-030 The bench SHALL cover timeout with the macro defined and TIMEOUT=4, responder never acking -> cyc high exactly 4 cycles; rsp_err=1, rsp_dat=0; a repeat run with ack on the 4th cycle -> rsp_err=0.
REQ-031 The bench SHALL cover reset mid-BUS: wb_rst_n pulsed low in 2nd BUS cycle -> cyc/stb low without waiting for a clock edge; no rsp_valid; next command completes normally.
REQ-032 The bench SHALL cover back-to-back commands with cmd_valid held high for 4 commands -> one idle cyc-low cycle minimum between each; responses in order with matching data.
